// File: rtl/vga_timing_pkg.sv
// Shared raster timing, lock-state encoding and pixel packing for the VGA capture receiver.
// Default timing is the 640x480 raster: 800 clocks per line, 521 lines per frame.
package vga_timing_pkg;

    localparam int H_ACTIVE_M1  = 639;
    localparam int H_SYNC_START = 655;
    localparam int H_SYNC_END   = 751;
    localparam int H_TOTAL_M1   = 799;

    localparam int V_ACTIVE_M1  = 479;
    localparam int V_SYNC_START = 489;
    localparam int V_SYNC_END   = 491;
    localparam int V_TOTAL_M1   = 520;

    // Back porch counts from the first counter value after the sync pulse ends.
    localparam int DEF_H_ACTIVE = H_ACTIVE_M1 + 1;
    localparam int DEF_H_TOTAL  = H_TOTAL_M1 + 1;
    localparam int DEF_H_BP     = H_TOTAL_M1 - H_SYNC_END;
    localparam int DEF_V_ACTIVE = V_ACTIVE_M1 + 1;
    localparam int DEF_V_TOTAL  = V_TOTAL_M1 + 1;
    localparam int DEF_V_BP     = V_TOTAL_M1 - V_SYNC_END;

    localparam int PIX_COLOR_W = 6;
    localparam int PIX_DATA_W  = 8;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } lock_state_e;

    function automatic logic [15:0] crc16_ccitt8(
        input logic [15:0] crc,
        input logic [7:0]  data
    );
        logic [15:0] c;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            if (c[15] ^ data[i]) begin
                c = {c[14:0], 1'b0} ^ CRC_POLY;
            end else begin
                c = {c[14:0], 1'b0};
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// Two-flop synchroniser with rise/fall pulses on the synchronised level.
// Flops reset to the idle level so a released reset never fakes an edge.
module vga_sync_edge #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
            prev_q <= RESET_VAL;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rise = sync_q & ~prev_q;
    assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/vga_capture_rx.sv
// VGA raster receiver: recovers X/Y from HS/VS, locks on timing, emits pixel writes.
// Build option VGA_RX_CRC_EN adds a per-frame CRC-16-CCITT of the written pixels.
module vga_capture_rx
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_TOTAL  = DEF_H_TOTAL,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_TOTAL  = DEF_V_TOTAL,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  vga_hs,
    input  logic                  vga_vs,
    input  logic [3:0]            vga_r,
    input  logic [3:0]            vga_g,
    input  logic [3:0]            vga_b,
    output logic                  pix_we,
    output logic [18:0]           pix_addr,
    output logic [PIX_DATA_W-1:0] pix_data,
    output logic [9:0]            raster_x,
    output logic [8:0]            raster_y,
    output logic                  locked,
    output logic                  frame_start,
    output logic [7:0]            err_count,
    output logic [15:0]           frame_crc
);

    localparam logic [10:0] H_BP_L    = 11'(H_BP);
    localparam logic [10:0] H_END_L   = 11'(H_BP + H_ACTIVE);
    localparam logic [10:0] H_LOSS_L  = 11'(2 * H_TOTAL);
    localparam logic [11:0] H_TOTAL_L = 12'(H_TOTAL);
    localparam logic [9:0]  V_BP_L    = 10'(V_BP);
    localparam logic [9:0]  V_END_L   = 10'(V_BP + V_ACTIVE);
    localparam logic [9:0]  V_TOTAL_L = 10'(V_TOTAL);

    logic hs_rise, hs_fall;
    logic vs_rise, vs_fall;

    vga_sync_edge u_hs_sync (
        .clk   (clk),
        .reset (reset),
        .din   (vga_hs),
        .rise  (hs_rise),
        .fall  (hs_fall)
    );

    vga_sync_edge u_vs_sync (
        .clk   (clk),
        .reset (reset),
        .din   (vga_vs),
        .rise  (vs_rise),
        .fall  (vs_fall)
    );

    logic unused_ok;
    assign unused_ok = ^{vga_r[1:0], vga_g[1:0], vga_b[1:0], hs_fall, vs_fall};

    logic [PIX_COLOR_W-1:0] rgb1_q, rgb2_q;
    logic [10:0] hcnt_q, hcnt_d;
    logic [9:0]  vcnt_q, vcnt_d;
    lock_state_e state_q, state_d;
    logic        bad_q, bad_d;
    logic [7:0]  err_q, err_d;
    logic        locked_q, locked_d;
    logic        pix_we_q, pix_we_d;
    logic [9:0]  raster_x_q, raster_x_d;
    logic [8:0]  raster_y_q, raster_y_d;
    logic [PIX_DATA_W-1:0] pix_data_q, pix_data_d;
    logic        frame_start_q;

    logic [11:0] line_len;
    logic        line_bad, frame_bad, sync_loss;
    logic        h_act, v_act;

    always_comb begin
        line_len  = {1'b0, hcnt_q} + 12'd1;
        line_bad  = hs_rise && (line_len != H_TOTAL_L);
        frame_bad = vs_rise && (vcnt_q != V_TOTAL_L);
        sync_loss = (hcnt_q == H_LOSS_L) && !hs_rise;
        h_act     = (hcnt_q >= H_BP_L) && (hcnt_q < H_END_L);
        v_act     = (vcnt_q >= V_BP_L) && (vcnt_q < V_END_L);
    end

    always_comb begin
        hcnt_d = hcnt_q;
        if (hs_rise) begin
            hcnt_d = '0;
        end else if (hcnt_q != 11'h7FF) begin
            hcnt_d = hcnt_q + 11'd1;
        end
        vcnt_d = vcnt_q;
        if (vs_rise) begin
            vcnt_d = '0;
        end else if (hs_rise) begin
            vcnt_d = vcnt_q + 10'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        bad_d   = bad_q;
        err_d   = err_q;
        unique case (state_q)
            SEARCH: begin
                if (vs_rise) begin
                    state_d = CHECK;
                    bad_d   = 1'b0;
                end
            end
            CHECK: begin
                if (line_bad) begin
                    bad_d = 1'b1;
                end
                if (vs_rise) begin
                    if (!frame_bad && !bad_q && !line_bad) begin
                        state_d = LOCKED;
                    end
                    bad_d = 1'b0;
                end
            end
            LOCKED: begin
                if (line_bad || frame_bad || sync_loss) begin
                    state_d = SEARCH;
                    if (err_q != 8'hFF) begin
                        err_d = err_q + 8'd1;
                    end
                end
            end
            default: state_d = SEARCH;
        endcase
        locked_d = (state_d == LOCKED);
    end

    // Write gating uses the next state so pix_we falls together with locked.
    always_comb begin
        pix_we_d   = locked_d && h_act && v_act;
        raster_x_d = raster_x_q;
        raster_y_d = raster_y_q;
        pix_data_d = pix_data_q;
        if (pix_we_d) begin
            raster_x_d = 10'(hcnt_q - H_BP_L);
            raster_y_d = 9'(vcnt_q - V_BP_L);
            pix_data_d = {2'b00, rgb2_q};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rgb1_q        <= '0;
            rgb2_q        <= '0;
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            state_q       <= SEARCH;
            bad_q         <= 1'b0;
            err_q         <= '0;
            locked_q      <= 1'b0;
            pix_we_q      <= 1'b0;
            raster_x_q    <= '0;
            raster_y_q    <= '0;
            pix_data_q    <= '0;
            frame_start_q <= 1'b0;
        end else begin
            rgb1_q        <= {vga_r[3:2], vga_g[3:2], vga_b[3:2]};
            rgb2_q        <= rgb1_q;
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            state_q       <= state_d;
            bad_q         <= bad_d;
            err_q         <= err_d;
            locked_q      <= locked_d;
            pix_we_q      <= pix_we_d;
            raster_x_q    <= raster_x_d;
            raster_y_q    <= raster_y_d;
            pix_data_q    <= pix_data_d;
            frame_start_q <= vs_rise;
        end
    end

`ifdef VGA_RX_CRC_EN
    logic [15:0] crc_q, crc_d;
    logic [15:0] frame_crc_q, frame_crc_d;

    always_comb begin
        crc_d       = crc_q;
        frame_crc_d = frame_crc_q;
        if (vs_rise) begin
            frame_crc_d = crc_q;
            crc_d       = CRC_INIT;
        end else if (pix_we_q) begin
            crc_d = crc16_ccitt8(crc_q, pix_data_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            crc_q       <= CRC_INIT;
            frame_crc_q <= '0;
        end else begin
            crc_q       <= crc_d;
            frame_crc_q <= frame_crc_d;
        end
    end

    assign frame_crc = frame_crc_q;
`else
    assign frame_crc = '0;
`endif

    assign pix_we      = pix_we_q;
    assign pix_addr    = {raster_x_q, raster_y_q};
    assign pix_data    = pix_data_q;
    assign raster_x    = raster_x_q;
    assign raster_y    = raster_y_q;
    assign locked      = locked_q;
    assign frame_start = frame_start_q;
    assign err_count   = err_q;

endmodule

// File: tb/tb_vga_capture_rx.sv
// Directed bench for vga_capture_rx on a reduced 16x8 raster (28 clocks x 14 lines).
// The generator drives pixel (x,y) so that its write appears 3 clocks later.
module tb_vga_capture_rx;

    localparam int HA  = 16;
    localparam int HT  = 28;
    localparam int HBP = 4;
    localparam int VA  = 8;
    localparam int VT  = 14;
    localparam int VBP = 3;
    localparam int HSE = HT - 1 - HBP;
    localparam int HSS = HSE - 4;
    localparam int VSE = VT - VBP;
    localparam int VSS = VSE - 2;
    localparam int NPIX = HA * VA;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        vga_hs = 1'b1;
    logic        vga_vs = 1'b1;
    logic [3:0]  vga_r = '0;
    logic [3:0]  vga_g = '0;
    logic [3:0]  vga_b = '0;
    logic        pix_we;
    logic [18:0] pix_addr;
    logic [7:0]  pix_data;
    logic [9:0]  raster_x;
    logic [8:0]  raster_y;
    logic        locked;
    logic        frame_start;
    logic [7:0]  err_count;
    logic [15:0] frame_crc;

    vga_capture_rx #(
        .H_ACTIVE (HA),
        .H_TOTAL  (HT),
        .H_BP     (HBP),
        .V_ACTIVE (VA),
        .V_TOTAL  (VT),
        .V_BP     (VBP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .vga_hs      (vga_hs),
        .vga_vs      (vga_vs),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .pix_we      (pix_we),
        .pix_addr    (pix_addr),
        .pix_data    (pix_data),
        .raster_x    (raster_x),
        .raster_y    (raster_y),
        .locked      (locked),
        .frame_start (frame_start),
        .err_count   (err_count),
        .frame_crc   (frame_crc)
    );

    always #5 clk = ~clk;

    int gf = 0;
    int gh = 0;
    int gv = 0;
    bit short_line = 1'b0;
    bit hs_hold = 1'b0;
    bit flip = 1'b0;
    int n_chk = 0;
    int n_pass = 0;
    int n_fail = 0;
    int we_total = 0;

    always @(negedge clk) begin
        if (pix_we === 1'b1) we_total++;
    end

    task automatic tick();
        logic [3:0] r, g, b;
        @(posedge clk);
        #1;
        vga_hs = hs_hold || !(gh >= HSS && gh < HSE);
        vga_vs = !(gv >= VSS && gv < VSE);
        r = '0;
        g = '0;
        b = '0;
        if (gh < HA && gv < VA) begin
            r = 4'(gh);
            g = 4'(gv + 8);
            b = 4'(gh + gv);
            if (gh == 5 && gv == 7) begin
                r = 4'hF;
                g = 4'h0;
                b = 4'hA;
            end
            if (flip && gh == 2 && gv == 2) r = ~r;
        end
        vga_r = r;
        vga_g = g;
        vga_b = b;
        gh++;
        if (gh >= (short_line ? HT - 1 : HT)) begin
            gh = 0;
            short_line = 1'b0;
            gv++;
            if (gv == VT) begin
                gv = 0;
                gf++;
            end
        end
    endtask

    task automatic run_to(input int f, input int v, input int h);
        int guard;
        guard = 0;
        while (!(gf == f && gv == v && gh == h)) begin
            tick();
            guard++;
            if (guard > 20000) begin
                $display("FAIL run_to timeout: at %0d/%0d/%0d want %0d/%0d/%0d",
                         gf, gv, gh, f, v, h);
                $fatal(1, "generator position never reached");
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    int w0, w1, w2, w3, w4;
    logic [15:0] crc_a;

    initial begin
        reset = 1'b1;
        tick();
        tick();
        tick();
        chk("rst_flags", {pix_we, locked, frame_start}, 3'b000);
        chk("rst_err", err_count, 8'd0);
        chk("rst_addr_data", {pix_addr, pix_data}, 27'd0);
        chk("rst_raster", {raster_x, raster_y}, 19'd0);
        chk("rst_crc", frame_crc, 16'd0);
        reset = 1'b0;

        run_to(0, 11, 4);
        chk("f0_vs_pulse", {frame_start, locked}, 2'b10);
        run_to(0, 11, 5);
        chk("f0_vs_pulse_end", frame_start, 1'b0);

        run_to(1, 0, 0);
        w0 = we_total;
        run_to(1, 11, 3);
        chk("f1_not_locked", locked, 1'b0);
        chk("f1_no_we_check", 32'(we_total - w0), 32'd0);
        tick();
        chk("f1_locked", {locked, frame_start}, 2'b11);

        run_to(2, 0, 0);
        w1 = we_total;
        run_to(2, 0, 4);
        chk("first_write", {pix_we, pix_addr}, {1'b1, 10'd0, 9'd0});
        run_to(2, 7, 9);
        chk("x5y7_addr", {pix_we, pix_addr}, {1'b1, 10'd5, 9'd7});
        chk("x5y7_data", pix_data, 8'h32);
        chk("x5y7_raster", {raster_x, raster_y}, {10'd5, 9'd7});
        run_to(2, 7, 19);
        chk("last_write", {pix_we, pix_addr}, {1'b1, 10'd15, 9'd7});
        run_to(2, 7, 20);
        chk("after_last", pix_we, 1'b0);
        run_to(2, 9, 0);
        chk("f2_count", 32'(we_total - w1), 32'(NPIX));

        run_to(2, 11, 4);
        crc_a = frame_crc;
`ifdef VGA_RX_CRC_EN
        chk("crc_nonzero", {31'd0, frame_crc != 16'd0}, 32'd1);
`else
        chk("crc_tied_a", frame_crc, 16'd0);
`endif
        run_to(3, 11, 4);
`ifdef VGA_RX_CRC_EN
        chk("crc_same", frame_crc, crc_a);
`else
        chk("crc_tied_b", frame_crc, 16'd0);
`endif
        run_to(4, 0, 0);
        flip = 1'b1;
        run_to(4, 9, 0);
        flip = 1'b0;
        run_to(4, 11, 4);
`ifdef VGA_RX_CRC_EN
        chk("crc_changed", {31'd0, frame_crc != crc_a}, 32'd1);
`else
        chk("crc_tied_c", frame_crc, 16'd0);
`endif

        run_to(5, 3, 0);
        chk("pre_short", {locked, err_count}, {1'b1, 8'd0});
        short_line = 1'b1;
        run_to(5, 5, 0);
        chk("short_unlock", {locked, err_count}, {1'b0, 8'd1});
        w2 = we_total;
        run_to(6, 11, 3);
        chk("short_no_we", 32'(we_total - w2), 32'd0);
        chk("short_not_yet", locked, 1'b0);
        tick();
        chk("short_relock", locked, 1'b1);
        run_to(7, 0, 0);
        w3 = we_total;
        run_to(7, 9, 0);
        chk("f7_count", 32'(we_total - w3), 32'(NPIX));

        run_to(8, 1, 0);
        chk("pre_loss", locked, 1'b1);
        hs_hold = 1'b1;
        run_to(8, 3, 4);
        hs_hold = 1'b0;
        chk("sync_loss", {locked, err_count}, {1'b0, 8'd2});

        run_to(10, 4, 10);
        chk("pre_reset", {pix_we, locked, err_count}, {2'b11, 8'd2});
        reset = 1'b1;
        tick();
        chk("mid_rst_flags", {pix_we, locked, frame_start}, 3'b000);
        chk("mid_rst_err", err_count, 8'd0);
        chk("mid_rst_addr", {pix_addr, pix_data}, 27'd0);
        chk("mid_rst_raster", {raster_x, raster_y}, 19'd0);
        reset = 1'b0;

        run_to(10, 11, 4);
        chk("rst_check", {frame_start, locked}, 2'b10);
        run_to(11, 11, 3);
        chk("rst_not_yet", locked, 1'b0);
        tick();
        chk("rst_relock", {locked, err_count}, {1'b1, 8'd0});
        run_to(12, 0, 0);
        w4 = we_total;
        run_to(12, 9, 0);
        chk("f12_count", 32'(we_total - w4), 32'(NPIX));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
